// File: rtl/rf1_fifo_ctrl_if.sv
// Push/pop stream and RAM-port bundle for rf1_fifo_ctrl.
// slave  : the FIFO controller side.
// master : the environment side (producer, consumer and the RAM itself).
interface rf1_fifo_ctrl_if #(
  parameter int N     = 8,
  parameter int WIDTH = 7
);
  // push stream
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  // pop stream
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [WIDTH:0]   count;
  // single-port RAM
  logic             ram_en;
  logic             ram_wr;
  logic [WIDTH-1:0] ram_addr;
  logic [N-1:0]     ram_wdata;
  logic [N-1:0]     ram_rdata;

  modport slave (
    input  in_valid, in_data, out_ready, ram_rdata,
    output in_ready, out_valid, out_data, count,
           ram_en, ram_wr, ram_addr, ram_wdata
  );

  modport master (
    output in_valid, in_data, out_ready, ram_rdata,
    input  in_ready, out_valid, out_data, count,
           ram_en, ram_wr, ram_addr, ram_wdata
  );
endinterface

// File: rtl/rf1_fifo_ctrl.sv
// FIFO controller in front of a single-port register-file RAM with a
// 1-cycle registered read. Reads (prefetch into the output stage) have
// fixed priority over writes; the port carries at most one access per
// cycle. The output stage is either the live RAM read data (rd_pend) or
// a holding register captured when the consumer stalls.
module rf1_fifo_ctrl #(
  parameter int M     = 128,
  parameter int N     = 8,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  rf1_fifo_ctrl_if.slave   bus
);

  localparam logic [WIDTH:0]   DEPTH = (WIDTH+1)'(M);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(M - 1);

  logic [WIDTH-1:0] wptr_q, wptr_d;
  logic [WIDTH-1:0] rptr_q, rptr_d;
  logic [WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             hold_valid_q, hold_valid_d;
  logic [N-1:0]     hold_data_q, hold_data_d;

  logic             out_valid;
  logic             rd_go;
  logic             wr_go;
  logic             in_ready;

  // Output stage view; the two sources are mutually exclusive.
  assign out_valid = rd_pend_q | hold_valid_q;

  // Port arbitration: a read is issued whenever data is buffered and the
  // output stage will have room next cycle. Writes take the leftover slots,
  // so in_ready depends on out_ready but never on in_valid.
  always_comb begin
    rd_go    = 1'b0;
    in_ready = 1'b0;
    wr_go    = 1'b0;
    if (reset_n) begin
      rd_go    = (ram_cnt_q != '0) && (!out_valid || bus.out_ready);
      in_ready = (ram_cnt_q < DEPTH) && !rd_go;
      wr_go    = bus.in_valid && in_ready;
    end
  end

  // RAM port drive; address/write strobe are only meaningful with ram_en.
  always_comb begin
    bus.ram_en    = rd_go | wr_go;
    bus.ram_wr    = wr_go;
    bus.ram_addr  = wr_go ? wptr_q : rptr_q;
    bus.ram_wdata = bus.in_data;
  end

  // Stream-side outputs.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.out_data  = rd_pend_q ? bus.ram_rdata : hold_data_q;
    bus.count     = ram_cnt_q + {{WIDTH{1'b0}}, out_valid};
  end

  // Next-state: pointers wrap at M-1 (M need not be a power of two),
  // occupancy moves by at most one, output stage captures stalled data.
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    ram_cnt_d    = ram_cnt_q;
    rd_pend_d    = rd_go;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;

    if (wr_go) begin
      wptr_d    = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q + 1'b1;
    end
    if (rd_go) begin
      rptr_d    = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q - 1'b1;
    end

    // Always capture the live read word so out_data keeps the last
    // presented value once out_valid drops; only a stall makes it valid.
    if (rd_pend_q) begin
      hold_data_d = bus.ram_rdata;
      if (!bus.out_ready) hold_valid_d = 1'b1;
    end
    if (hold_valid_q && bus.out_ready) hold_valid_d = 1'b0;
  end

  // State register; reset discards pending reads and held data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      ram_cnt_q    <= '0;
      rd_pend_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      ram_cnt_q    <= ram_cnt_d;
      rd_pend_q    <= rd_pend_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

endmodule

// File: tb/tb_rf1_fifo_ctrl.sv
// Scoreboard bench for rf1_fifo_ctrl: a depth-4 instance for latency,
// backpressure, arbitration and reset, a depth-3 instance for wrap.
module tb_rf1_fifo_ctrl;
  localparam int N  = 8;
  localparam int M4 = 4;
  localparam int W4 = 2;
  localparam int M3 = 3;
  localparam int W3 = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  rf1_fifo_ctrl_if #(.N(N), .WIDTH(W4)) b4();
  rf1_fifo_ctrl_if #(.N(N), .WIDTH(W3)) b3();

  rf1_fifo_ctrl #(.M(M4), .N(N), .WIDTH(W4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(b4.slave));
  rf1_fifo_ctrl #(.M(M3), .N(N), .WIDTH(W3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(b3.slave));

  // RAM models: 1-cycle registered read, Data held, Data cleared by reset
  logic [N-1:0] mem4 [0:(1<<W4)-1];
  logic [N-1:0] mem3 [0:(1<<W3)-1];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) b4.ram_rdata <= '0;
    else if (b4.ram_en) begin
      if (b4.ram_wr) mem4[b4.ram_addr] <= b4.ram_wdata;
      else           b4.ram_rdata <= mem4[b4.ram_addr];
    end
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) b3.ram_rdata <= '0;
    else if (b3.ram_en) begin
      if (b3.ram_wr) mem3[b3.ram_addr] <= b3.ram_wdata;
      else           b3.ram_rdata <= mem3[b3.ram_addr];
    end
  end

  int errs = 0;
  int checks = 0;
  logic [N-1:0] q4[$];
  logic [N-1:0] q3[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected data on every handshake, plus per-cycle rules
  int wexp3 = 0;
  int rexp3 = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      wexp3 = 0;
      rexp3 = 0;
    end else begin
      if (b4.out_valid && b4.out_ready) begin
        if (q4.size() == 0) chk("pop4_unexpected", 1, 0);
        else chk("pop4_data", b4.out_data, q4.pop_front());
      end
      if (b3.out_valid && b3.out_ready) begin
        if (q3.size() == 0) chk("pop3_unexpected", 1, 0);
        else chk("pop3_data", b3.out_data, q3.pop_front());
      end
      if (dut4.rd_pend_q || dut4.hold_valid_q)
        chk("rdpend_hold_excl4", dut4.rd_pend_q & dut4.hold_valid_q, 0);
      if (b4.ram_en && !b4.ram_wr)
        chk("rd_wr_same_cycle4", b4.in_valid & b4.in_ready, 0);
      if (b3.ram_en) begin
        if (b3.ram_wr) begin
          chk("wr_addr3", b3.ram_addr, wexp3);
          wexp3 = (wexp3 + 1) % M3;
        end else begin
          chk("rd_addr3", b3.ram_addr, rexp3);
          rexp3 = (rexp3 + 1) % M3;
        end
      end
      if (b3.count != 0) chk("count3_max", b3.count > 4, 0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Push one word on the depth-4 instance, waiting a bounded time for in_ready
  task automatic push4(input logic [N-1:0] d, input bit exp_acc);
    bit acc;
    acc = 1'b0;
    b4.in_valid = 1'b1;
    b4.in_data  = d;
    if (exp_acc) q4.push_back(d);
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      if (b4.in_ready) acc = 1'b1;
      step();
    end
    b4.in_valid = 1'b0;
    chk("push4_accept", acc, exp_acc);
  endtask

  task automatic drain4(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (b4.count == 0 && !b4.out_valid) done = 1'b1;
      step();
    end
    chk(name, done, 1);
  endtask

  logic [3:0] arb_exp = 4'b1000;

  initial begin
    b4.in_valid = 1'b1; b4.in_data = 8'h77; b4.out_ready = 1'b1;
    b3.in_valid = 1'b0; b3.in_data = '0;    b3.out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #2;
    // reset state with requests asserted
    chk("rst_in_ready", b4.in_ready, 0);
    chk("rst_ram_en", b4.ram_en, 0);
    chk("rst_out_valid", b4.out_valid, 0);
    chk("rst_count", b4.count, 0);
    chk("rst_out_data", b4.out_data, 0);
    step(); step();
    b4.in_valid = 1'b0;
    reset_n = 1'b1;
    step();

    // latency: write t, read t+1, valid t+2, empty t+3
    b4.out_ready = 1'b1;
    b4.in_valid = 1'b1; b4.in_data = 8'h5A;
    q4.push_back(8'h5A);
    @(negedge clk);
    chk("lat_t_in_ready", b4.in_ready, 1);
    chk("lat_t_ram_en", b4.ram_en, 1);
    chk("lat_t_ram_wr", b4.ram_wr, 1);
    chk("lat_t_addr", b4.ram_addr, 0);
    chk("lat_t_wdata", b4.ram_wdata, 8'h5A);
    step();
    b4.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_t1_ram_en", b4.ram_en, 1);
    chk("lat_t1_ram_wr", b4.ram_wr, 0);
    chk("lat_t1_addr", b4.ram_addr, 0);
    chk("lat_t1_out_valid", b4.out_valid, 0);
    step();
    @(negedge clk);
    chk("lat_t2_out_valid", b4.out_valid, 1);
    chk("lat_t2_count", b4.count, 1);
    step();
    @(negedge clk);
    chk("lat_t3_count", b4.count, 0);
    chk("lat_t3_out_valid", b4.out_valid, 0);
    chk("lat_t3_out_data_held", b4.out_data, 8'h5A);
    step();

    // fill and backpressure: 5 accepted, 6th refused
    b4.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push4(N'(i), 1'b1);
    push4(8'h06, 1'b0);
    @(negedge clk);
    chk("full_count", b4.count, M4 + 1);
    chk("full_in_ready", b4.in_ready, 0);
    step();
    b4.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("drain_consecutive", b4.out_valid, 1);
      step();
    end
    @(negedge clk);
    chk("drain_out_valid", b4.out_valid, 0);
    chk("drain_count", b4.count, 0);
    step();

    // arbitration: 3 in RAM + 1 held, then push continuously while popping
    b4.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push4(8'h21 + N'(i), 1'b1);
    @(negedge clk);
    chk("arb_count", b4.count, 4);
    step();
    b4.out_ready = 1'b1;
    b4.in_valid = 1'b1; b4.in_data = 8'h25;
    q4.push_back(8'h25);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arb_in_ready", b4.in_ready, arb_exp[i]);
      step();
    end
    b4.in_valid = 1'b0;
    drain4("arb_drain");

    // wrap on depth 3: back-to-back push with continuous pop
    b3.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bit acc;
      acc = 1'b0;
      b3.in_valid = 1'b1;
      b3.in_data = 8'h10 + N'(i);
      q3.push_back(8'h10 + N'(i));
      for (int k = 0; k < 8 && !acc; k++) begin
        @(negedge clk);
        if (b3.in_ready) acc = 1'b1;
        step();
      end
      chk("wrap_accept", acc, 1);
    end
    b3.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    @(negedge clk);
    chk("wrap_count_end", b3.count, 0);
    chk("wrap_q_empty", q3.size(), 0);
    step();

    // mid-operation reset with count=3 and held data
    b4.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push4(8'h31 + N'(i), 1'b1);
    @(negedge clk);
    chk("mid_count", b4.count, 3);
    chk("mid_hold_valid", dut4.hold_valid_q, 1);
    step();
    b4.in_valid = 1'b1; b4.in_data = 8'h77; b4.out_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", b4.out_valid, 0);
    chk("mid_rst_count", b4.count, 0);
    chk("mid_rst_in_ready", b4.in_ready, 0);
    chk("mid_rst_ram_en", b4.ram_en, 0);
    chk("mid_rst_out_data", b4.out_data, 0);
    q4.delete();
    step();
    b4.in_valid = 1'b0;
    reset_n = 1'b1;
    step();
    push4(8'hAA, 1'b1);
    drain4("mid_drain");

    chk("q4_empty", q4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rf1_fifo_ctrl.md
Name: rf1_fifo_ctrl

Overview:
Synchronous FIFO controller that sits directly upstream of the single-port register-file RAM (M x N, one access per cycle, 1-cycle registered read).
- Converts a valid/ready push stream and a valid/ready pop stream into the RAM's En/Wr/Addr/WrData port.
- Consumes the RAM read data (Data) and presents it on a hold/bypass output stage.
- Arbitrates the single RAM port between writes and prefetch reads.

Parameters:
M, 128, FIFO depth in RAM entries; any value >= 2, not required to be a power of 2.
N, 8, data width.
WIDTH, 7, RAM address width; must satisfy 2^WIDTH >= M.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
in_valid  in  1  push request.
in_ready  out  1  push accepted when in_valid && in_ready.
in_data  in  N  push data.
out_valid  out  1  pop data available.
out_ready  in  1  consumer accepts; a pop occurs when out_valid && out_ready.
out_data  out  N  pop data.
count  out  WIDTH+1  total occupancy = ram_cnt + out_valid; range 0..M+1.
ram_en  out  1  to RAM En.
ram_wr  out  1  to RAM Wr.
ram_addr  out  WIDTH  to RAM Addr.
ram_wdata  out  N  to RAM WrData; equals in_data.
ram_rdata  in  N  from RAM Data; valid the cycle after a read is issued, then held.

Behaviour:
- Registered state:
  - wptr, rptr: 0..M-1; each increments on use and wraps from M-1 to 0.
  - ram_cnt: 0..M.
  - rd_pend: a read was issued last cycle.
  - hold_valid, hold_data: output holding register.
- Reset (asynchronous, reset_n low): all state cleared to 0. Resulting outputs: out_valid=0, count=0, out_data=0.
- While reset_n is low, in_ready=0 and ram_en=0 (combinational gating).
- RAM contents are not cleared. Stale entries are never read because ram_cnt=0.
- Read issue: R = (ram_cnt != 0) && (!out_valid || out_ready).
  - Action: ram_en=1, ram_wr=0, ram_addr=rptr; rptr advances.
  - Next cycle: rd_pend=1.
- Write:
  - in_ready = (ram_cnt < M) && !R. Reads have fixed priority over writes.
  - On in_valid && in_ready: ram_en=1, ram_wr=1, ram_addr=wptr; wptr advances.
- Port use: at most one RAM access per cycle. When neither a read nor a write occurs, ram_en=0; ram_wr and ram_addr are don't-care.
- ram_cnt next value: ram_cnt + write - R. A write and a read never occur in the same cycle.
- Output stage:
  - out_valid = rd_pend || hold_valid.
  - out_data = rd_pend ? ram_rdata : hold_data.
  - If rd_pend && !out_ready: hold_data <= ram_rdata, hold_valid <= 1.
  - If hold_valid && out_ready: hold_valid <= 0.
  - rd_pend and hold_valid are never both 1 (guaranteed by R). Verification asserts this.
- out_data stability: while out_valid && !out_ready, out_data stays stable.
- When out_valid=0, out_data keeps its last value.
- in_ready and ram_* are combinational from state, in_valid and out_ready. No combinational path from in_valid to in_ready.
- Latency: a push accepted in cycle t appears on out_valid no earlier than t+2.
  - t+1: ram_cnt=1 and the read is issued.
  - t+2: rd_pend=1.
- Throughput: with in_valid held low and out_ready=1, pops sustain 1 per cycle.
- Full: when ram_cnt=M, in_ready=0 and in_data is ignored.
- Empty: when ram_cnt=0, no read is issued. Push attempts to a full FIFO are dropped by handshake, never silently written.
- Reset mid-operation: pending reads and held data are discarded. The RAM's own Data register is cleared by the same reset.

Test Plan:
- Reset: reset_n low with in_valid=1, out_ready=1 -> in_ready=0, ram_en=0, out_valid=0, count=0, out_data=0.
- Latency (M=4): push 0x5A at cycle t with out_ready=1 -> ram write to addr 0 at t; read of addr 0 at t+1; out_valid=1 with out_data=0x5A at t+2; count returns to 0 at t+3.
- Fill and backpressure (M=4): push 0x01..0x06 with out_ready=0 -> 5 accepted, count=5, 6th push sees in_ready=0. Then out_ready=1 -> pops 0x01..0x05 on 5 consecutive cycles.
- Arbitration: RAM holds 3 entries, out_ready=1, in_valid=1 continuously -> in_ready=0 while ram_cnt!=0; no cycle has both a read and a write.
- Wrap (M=3): 10 push/pop pairs of 0x10..0x19 -> addresses cycle 0,1,2,0,...; output order preserved; count never exceeds 4.
- Mid-operation reset: reset_n pulsed low with count=3 and hold_valid=1 -> out_valid=0 immediately. After release, push 0xAA -> first pop is 0xAA.
